// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory pipeline stage: funct3 encodings,
// wait-state FSM states, the EX/MEM register layout and byte-lane helpers.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = '0;

  // Size is funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] offset);
    case (size)
      2'b00:   return 4'b0001 << offset;
      2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/datamem_be.sv
// Word-organised data RAM with four byte-lane write enables,
// synchronous write and asynchronous read.
module datamem_be #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-3:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; clearing a RAM needs a per-word reset path
  // that real RAM macros lack, and software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, byte-lane store/load formatting,
// and a wait-state controller that stalls the pipeline for slow memories.
module memory_stage
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             MemReadE,
  input  logic [2:0]       Funct3E,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [4:0]       RdE,
  input  logic             FlushM,
  output logic             RegWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [4:0]       RdM,
  output logic             MemBusyM,
  output logic             MisalignM
);

  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  exmem_t     ex_d, ex_q;
  mem_state_e state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic       served_d, served_q;

  logic             mem_busy;
  logic [1:0]       offset;
  logic             is_access, misalign, valid_access;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] store_data, read_word, load_ext;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign offset       = ex_q.alu_result[1:0];
  assign is_access    = ex_q.mem_read | ex_q.mem_write;
  assign misalign     = is_access & is_misaligned(ex_q.funct3, offset);
  assign valid_access = is_access & ~misalign;

  // Busy depends only on registered state, so the hazard unit sees no loop.
  assign mem_busy = (state_q == S_WAIT) |
                    ((state_q == S_IDLE) & valid_access & HAS_WAIT & ~served_q);

  // NOTE: every combinational output gets a default first so that no path
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    ex_d = ex_q;
    if (!mem_busy) begin
      if (FlushM) begin
        ex_d = EXMEM_BUBBLE;
      end else begin
        ex_d.reg_write  = RegWriteE;
        ex_d.mem_write  = MemWriteE;
        ex_d.mem_read   = MemReadE;
        ex_d.result_src = ResultSrcE;
        ex_d.funct3     = Funct3E;
        ex_d.alu_result = ALUResultE;
        ex_d.write_data = WriteDataE;
        ex_d.pc_plus4   = PCPlus4E;
        ex_d.rd         = RdE;
      end
    end
  end

  // The first busy cycle is spent in IDLE; WAIT covers the remaining N-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        if (mem_busy) begin
          cnt_d    = 4'(WAIT_STATES);
          served_d = 1'b1;
          if (WAIT_STATES > 1) state_d = S_WAIT;
        end else begin
          cnt_d    = '0;
          served_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= EXMEM_BUBBLE;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      served_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
    end
  end

  // Stores commit only in the final, non-busy cycle, so exactly once.
  assign mem_we = ex_q.mem_write & valid_access & ~mem_busy;
  assign mem_be = byte_enable(ex_q.funct3[1:0], offset);

  always_comb begin
    case (ex_q.funct3[1:0])
      2'b00:   store_data = {4{ex_q.write_data[7:0]}};
      2'b01:   store_data = {2{ex_q.write_data[15:0]}};
      default: store_data = ex_q.write_data;
    endcase
  end

  datamem_be #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_datamem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (ex_q.alu_result[ADDR_WIDTH-1:2]),
    .wdata (store_data),
    .rdata (read_word)
  );

  assign byte_sel = read_word[8*offset +: 8];
  assign half_sel = offset[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    case (ex_q.funct3)
      F3_B:    load_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_W:    load_ext = read_word;
      F3_BU:   load_ext = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   load_ext = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_ext = '0;
    endcase
  end

  assign RegWriteM  = ex_q.reg_write & ~(ex_q.mem_read & misalign);
  assign ResultSrcM = ex_q.result_src;
  assign ALUResultM = ex_q.alu_result;
  assign ReadDataM  = (ex_q.mem_read & ~misalign) ? load_ext : '0;
  assign PCPlus4M   = ex_q.pc_plus4;
  assign RdM        = ex_q.rd;
  assign MemBusyM   = mem_busy;
  assign MisalignM  = misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: one instance with no wait states and one with three,
// checked against a byte-array memory model kept in the bench.
module tb_memory_stage;
  import mem_pkg::*;

  typedef struct packed {
    logic        rw, mw, mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr, wd, pc4;
    logic [4:0]  rd;
    logic        flush;
  } ins_t;

  typedef struct packed {
    logic [7:0]  busy;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu, rdata, pc4;
    logic [4:0]  rd;
    logic        mis;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   sel = 0;
  ins_t cur = '0;
  ins_t in0, in1;
  assign in0 = (sel == 0) ? cur : '0;
  assign in1 = (sel == 1) ? cur : '0;

  logic        rw_o[2], busy_o[2], mis_o[2];
  logic [1:0]  rs_o[2];
  logic [31:0] alu_o[2], rdm_o[2], pc4_o[2];
  logic [4:0]  rd_o[2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [2][4096];

  memory_stage #(.WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(in0.rw), .MemWriteE(in0.mw), .ResultSrcE(in0.rs), .MemReadE(in0.mr),
    .Funct3E(in0.f3), .ALUResultE(in0.addr), .WriteDataE(in0.wd), .PCPlus4E(in0.pc4),
    .RdE(in0.rd), .FlushM(in0.flush),
    .RegWriteM(rw_o[0]), .ResultSrcM(rs_o[0]), .ALUResultM(alu_o[0]), .ReadDataM(rdm_o[0]),
    .PCPlus4M(pc4_o[0]), .RdM(rd_o[0]), .MemBusyM(busy_o[0]), .MisalignM(mis_o[0])
  );

  memory_stage #(.WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(in1.rw), .MemWriteE(in1.mw), .ResultSrcE(in1.rs), .MemReadE(in1.mr),
    .Funct3E(in1.f3), .ALUResultE(in1.addr), .WriteDataE(in1.wd), .PCPlus4E(in1.pc4),
    .RdE(in1.rd), .FlushM(in1.flush),
    .RegWriteM(rw_o[1]), .ResultSrcM(rs_o[1]), .ALUResultM(alu_o[1]), .ReadDataM(rdm_o[1]),
    .PCPlus4M(pc4_o[1]), .RdM(rd_o[1]), .MemBusyM(busy_o[1]), .MisalignM(mis_o[1])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mk_rand();
    return $urandom;
  endfunction

  function automatic ins_t mk(input logic rw, input logic mw, input logic mr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd);
    ins_t i = '0;
    i.rw = rw; i.mw = mw; i.mr = mr; i.f3 = f3; i.addr = addr; i.wd = wd;
    i.rs  = 2'($urandom_range(0, 3));
    i.pc4 = mk_rand();
    i.rd  = 5'($urandom_range(1, 31));
    return i;
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input int a);
    if ((f3 == F3_H || f3 == F3_HU) && (a % 2) != 0) return 1'b1;
    if (f3 == F3_W && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr % 4096);
    b = mem_m[s][a];
    h = {mem_m[s][(a + 1) % 4096], mem_m[s][a]};
    case (f3)
      F3_B:    return 32'($signed(b));
      F3_BU:   return 32'(b);
      F3_H:    return 32'($signed(h));
      F3_HU:   return 32'(h);
      default: return {mem_m[s][(a + 3) % 4096], mem_m[s][(a + 2) % 4096], h};
    endcase
  endfunction

  function automatic obs_t predict(input int s, input ins_t i);
    obs_t p = '0;
    bit acc, mis;
    acc    = i.mr || i.mw;
    mis    = acc && misaligned(i.f3, int'(i.addr % 4));
    p.busy = (s == 1 && acc && !mis) ? 8'd3 : 8'd0;
    p.rw   = i.rw && !(i.mr && mis);
    p.rs   = i.rs;
    p.alu  = i.addr;
    p.rdata = (i.mr && !mis) ? model_load(s, i.addr, i.f3) : 32'h0;
    p.pc4  = i.pc4;
    p.rd   = i.rd;
    p.mis  = mis;
    return p;
  endfunction

  // Issues one instruction from a negedge and returns what MEM showed in its final cycle.
  task automatic exec(input int s, input ins_t i, input bit flush_busy, output obs_t o);
    int guard;
    int n;
    int a;
    sel = s;
    cur = i;
    @(posedge clk);
    @(negedge clk);
    cur = '0;
    cur.flush = flush_busy;
    o = '0;
    guard = 0;
    while (busy_o[s] === 1'b1 && guard < 40) begin
      o.busy = o.busy + 8'd1;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: MemBusyM still high after %0d cycles (limit 40)", guard);
    end
    cur.flush = 1'b0;
    o.rw = rw_o[s]; o.rs = rs_o[s]; o.alu = alu_o[s]; o.rdata = rdm_o[s];
    o.pc4 = pc4_o[s]; o.rd = rd_o[s]; o.mis = mis_o[s];
    a = int'(i.addr % 4096);
    if (i.mw && !i.flush && !misaligned(i.f3, a % 4)) begin
      n = (i.f3[1:0] == 2'b00) ? 1 : (i.f3[1:0] == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) mem_m[s][(a + k) % 4096] = i.wd[8*k +: 8];
    end
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({rw_o[s], rs_o[s], alu_o[s], rdm_o[s], pc4_o[s], rd_o[s], busy_o[s], mis_o[s]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got rw=%b rd=%0d alu=%h busy=%b, want all zero",
                 s, rw_o[s], rd_o[s], alu_o[s], busy_o[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    ins_t i;
    obs_t got, exp;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) begin
        i = mk(1'b0, 1'b1, 1'b0, F3_W, 32'(4 * w), mk_rand());
        exp = predict(s, i);
        exec(s, i, 1'b0, got);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL fill dut%0d w%0d: got %h want %h", s, w, got, exp);
        end
      end
    end
  endtask

  task automatic test_sw_lw();
    obs_t got;
    exec(0, mk(1'b0, 1'b1, 1'b0, F3_W, 32'h010, 32'hDEADBEEF), 1'b0, got);
    n_cmp++;
    if (got.busy !== 8'd0) begin
      n_bad++; $display("FAIL sw_busy: got %0d cycles want 0", got.busy);
    end
    exec(0, mk(1'b1, 1'b0, 1'b1, F3_W, 32'h010, 32'h0), 1'b0, got);
    n_cmp++;
    if (got.rdata !== 32'hDEADBEEF || got.busy !== 8'd0) begin
      n_bad++; $display("FAIL lw_after_sw: got %h busy %0d want deadbeef busy 0", got.rdata, got.busy);
    end
  endtask

  task automatic test_subword();
    obs_t got;
    logic [31:0] want [5];
    ins_t seq [5];
    exec(0, mk(1'b0, 1'b1, 1'b0, F3_B, 32'h013, {mk_rand()} & 32'hFFFFFF00 | 32'h80), 1'b0, got);
    seq[0] = mk(1'b1, 1'b0, 1'b1, F3_B,  32'h013, 32'h0); want[0] = 32'hFFFFFF80;
    seq[1] = mk(1'b1, 1'b0, 1'b1, F3_BU, 32'h013, 32'h0); want[1] = 32'h00000080;
    seq[2] = mk(1'b1, 1'b0, 1'b1, F3_W,  32'h010, 32'h0); want[2] = 32'h80ADBEEF;
    seq[3] = mk(1'b0, 1'b1, 1'b0, F3_H,  32'h012, 32'hABCD1234); want[3] = 32'h0;
    seq[4] = mk(1'b1, 1'b0, 1'b1, F3_H,  32'h012, 32'h0); want[4] = 32'h00001234;
    for (int k = 0; k < 5; k++) begin
      exec(0, seq[k], 1'b0, got);
      n_cmp++;
      if (got.rdata !== want[k] || got.rw !== seq[k].rw) begin
        n_bad++;
        $display("FAIL subword step%0d: got data %h rw %b want data %h rw %b",
                 k, got.rdata, got.rw, want[k], seq[k].rw);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t got;
    exec(0, mk(1'b1, 1'b0, 1'b1, F3_W, 32'h011, 32'h0), 1'b0, got);
    n_cmp++;
    if (got.mis !== 1'b1 || got.rdata !== 32'h0 || got.rw !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_lw: got mis %b data %h rw %b want 1 00000000 0", got.mis, got.rdata, got.rw);
    end
    exec(0, mk(1'b0, 1'b1, 1'b0, F3_W, 32'h011, 32'h11111111), 1'b0, got);
    n_cmp++;
    if (got.mis !== 1'b1) begin
      n_bad++; $display("FAIL misalign_sw_flag: got %b want 1", got.mis);
    end
    exec(0, mk(1'b1, 1'b0, 1'b1, F3_W, 32'h010, 32'h0), 1'b0, got);
    n_cmp++;
    if (got.rdata !== 32'h1234BEEF) begin
      n_bad++; $display("FAIL misalign_sw_nowrite: got %h want 1234beef", got.rdata);
    end
  endtask

  task automatic test_wait_states();
    obs_t got, exp;
    ins_t i;
    exec(1, mk(1'b0, 1'b1, 1'b0, F3_W, 32'h020, 32'hCAFEF00D), 1'b0, got);
    n_cmp++;
    if (got.busy !== 8'd3) begin
      n_bad++; $display("FAIL ws_sw_busy: got %0d cycles want 3", got.busy);
    end
    exec(1, mk(1'b1, 1'b0, 1'b1, F3_W, 32'h020, 32'h0), 1'b0, got);
    n_cmp++;
    if (got.busy !== 8'd3 || got.rdata !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL ws_lw: got busy %0d data %h want 3 cafef00d", got.busy, got.rdata);
    end
    // FlushM held high while busy must not disturb the store in MEM.
    exec(1, mk(1'b0, 1'b1, 1'b0, F3_H, 32'h022, 32'h0000A5A5), 1'b1, got);
    n_cmp++;
    if (got.busy !== 8'd3) begin
      n_bad++; $display("FAIL ws_flush_busy: got %0d cycles want 3", got.busy);
    end
    exec(1, mk(1'b1, 1'b0, 1'b1, F3_W, 32'h020, 32'h0), 1'b0, got);
    n_cmp++;
    if (got.rdata !== 32'hA5A5F00D) begin
      n_bad++; $display("FAIL ws_flush_ignored: got %h want a5a5f00d", got.rdata);
    end
    i = mk(1'b1, 1'b0, 1'b1, F3_H, 32'h021, 32'h0);
    exp = predict(1, i);
    exec(1, i, 1'b0, got);
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL ws_misaligned: got %h want %h", got, exp);
    end
  endtask

  task automatic test_flush();
    obs_t got, exp;
    ins_t i;
    for (int s = 0; s < 2; s++) begin
      i = mk(1'b1, 1'b1, 1'b0, F3_W, 32'h024, 32'hFFFFFFFF);
      i.rd = 5'd7;
      i.flush = 1'b1;
      exec(s, i, 1'b0, got);
      n_cmp++;
      if (got.rw !== 1'b0 || got.rd !== 5'd0 || got.busy !== 8'd0) begin
        n_bad++;
        $display("FAIL flush_bubble dut%0d: got rw %b rd %0d busy %0d want 0 0 0", s, got.rw, got.rd, got.busy);
      end
      i = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h024, 32'h0);
      exp = predict(s, i);
      exec(s, i, 1'b0, got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL flush_nowrite dut%0d: got %h want %h", s, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t got, exp;
    ins_t i;
    sel = 1;
    cur = mk(1'b0, 1'b1, 1'b0, F3_W, 32'h030, 32'h55555555);
    @(posedge clk);
    @(negedge clk);
    cur = '0;
    n_cmp++;
    if (busy_o[1] !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait_busy_before: got %b want 1", busy_o[1]);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rw_o[1], rs_o[1], alu_o[1], rdm_o[1], pc4_o[1], rd_o[1], busy_o[1], mis_o[1]} !== '0) begin
      n_bad++;
      $display("FAIL rst_wait_outputs: got busy %b alu %h rd %0d want all zero", busy_o[1], alu_o[1], rd_o[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h030, 32'h0);
    exp = predict(1, i);
    exec(1, i, 1'b0, got);
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL rst_wait_nowrite: got %h want %h", got, exp);
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    ins_t i;
    logic [2:0] ld_f3 [5];
    int s, op;
    logic [31:0] addr;
    ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;
    for (int n = 0; n < 300; n++) begin
      s    = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      addr = (32'($urandom_range(0, 255)) << 12) | 32'($urandom_range(0, 63));
      case (op)
        0:       i = mk(1'b1, 1'b0, 1'b1, ld_f3[$urandom_range(0, 4)], addr, mk_rand());
        1:       i = mk(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 2)), addr, mk_rand());
        default: i = mk(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), mk_rand(), mk_rand());
      endcase
      exp = predict(s, i);
      exec(s, i, 1'b0, got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random #%0d dut%0d op%0d addr %h f3 %0d: got %h want %h",
                 n, s, op, i.addr, i.f3, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_sw_lw();
    test_subword();
    test_misalign();
    test_wait_states();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Parametrised memory pipeline stage: the EX/MEM pipeline register, a byte-enabled data memory, and a wait-state controller. It sits between the execute stage and the MEM/WB register. It extends the single-cycle word-only memory stage with:
- sub-word loads and stores
- stall/flush control for the hazard unit
- configurable memory latency, with a busy signal back to the hazard unit.

## Interface
Parameters:
- WIDTH, 32, datapath width; fixed at 32 for RV32 sub-word semantics.
- ADDR_WIDTH, 12, byte-address bits used; memory depth is 2^(ADDR_WIDTH-2) words.
- WAIT_STATES, 0, extra cycles per load/store (0..15); 0 gives single-cycle behaviour.

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low; one clock domain.
- RegWriteE, MemWriteE  in  1 each  control from execute.
- ResultSrcE  in  2  result select from execute.
- MemReadE  in  1  instruction is a load.
- Funct3E  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultE, WriteDataE, PCPlus4E  in  WIDTH each  address / store data / PC+4.
- RdE  in  5  destination register.
- FlushM  in  1  load a bubble into the EX/MEM register.
- RegWriteM  out  1  qualified register write.
- ResultSrcM  out  2  result select.
- ALUResultM, ReadDataM, PCPlus4M  out  WIDTH each  address pass-through / extended load data / PC+4.
- RdM  out  5  destination register.
- MemBusyM  out  1  access in progress; hazard unit stalls F/D/E and holds this stage.
- MisalignM  out  1  registered access is misaligned.

## Operation
- **EX/MEM register**
  - Captures all E inputs on each rising edge unless MemBusyM=1, in which case it holds.
  - FlushM=1 with MemBusyM=0 loads a bubble: RegWriteM, MemWriteM, MemReadM, ResultSrcM, RdM, Funct3M all cleared.
  - FlushM while busy is ignored.
- **Store lanes**, from byte offset a=ALUResultM[1:0]:
  - SB: byte enable 1<<a, data WriteData[7:0] replicated ×4.
  - SH: enable 0011 or 1100 by a[1], data WriteData[15:0] replicated ×2.
  - SW: enable 1111.
- **Load extraction:** the selected byte or half is taken from the read word. B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- **Misalignment:** H/HU with a[0]=1, or W with a!=0, sets MisalignM. The access is then suppressed: no write, ReadDataM=0, RegWriteM forced 0 for loads.
- **Address range:** bits above ADDR_WIDTH-1 are ignored, so addresses wrap modulo memory size.
- **FSM states:** IDLE, WAIT.
  - IDLE: if a valid load/store is registered and WAIT_STATES>0, the counter loads WAIT_STATES and the FSM goes to WAIT.
  - WAIT: the counter decrements each cycle; when it reaches 1, the FSM returns to IDLE.
  - MemBusyM = (IDLE and access registered and WAIT_STATES>0 and not yet served) or WAIT. A served flag prevents re-entry for the same held instruction.
- **Non-memory instructions** never assert busy.
- **Reset:** every output register is 0, the FSM is IDLE, the counter and served flag are 0, and MemBusyM=0. Memory contents are not reset.
  - Reset asserted mid-WAIT aborts the access; any pending write is dropped.

## Timing
- **WAIT_STATES=0:**
  - The store is written at the rising edge that ends the cycle in which it occupies MEM.
  - Load ReadDataM is combinational from registered address and is valid in the same cycle.
- **WAIT_STATES=N:**
  - The instruction occupies MEM for N+1 cycles, and MemBusyM is high for the first N of them.
  - The write commits at the edge ending the final (not busy) cycle, exactly once.
  - ReadDataM is valid in the final cycle.
- **Back-to-back accesses:** each pays the full N+1 cycles, with no overlap.
- **Store then load to the same address** on consecutive instructions: the load sees the new data (write-first across cycles).

## Structure
- Package mem_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state enum.
  - Bubble constant for the pipeline register struct.
  - Byte-enable helper function.
- Sub-module datamem_be:
  - Word-organised RAM with 4 byte enables.
  - Synchronous write, asynchronous read.
  - Parameters WIDTH and ADDR_WIDTH.
- The lane/extend logic and FSM live in memory_stage.

## Test plan
- **SW then LW:** SW 0xDEADBEEF to 0x010, then LW 0x010 (WAIT_STATES=0) → ReadDataM=0xDEADBEEF, MemBusyM never high.
- **Sub-word stores and loads:** SB 0x80 to 0x013 over that word, then LB 0x013 → 0xFFFFFF80, LBU → 0x00000080, LW → 0x80ADBEEF. SH 0x1234 to 0x012, then LH → 0x00001234.
- **Misalignment:** LW to 0x011 → MisalignM=1, ReadDataM=0, RegWriteM=0. SW to 0x011 leaves memory unchanged.
- **Wait states:** WAIT_STATES=3, SW then LW → each holds MEM 4 cycles with MemBusyM high 3 cycles; the write occurs once; the LW returns the stored value.
- **Flush and reset:** FlushM with a store in E → no write, RdM=0, RegWriteM=0. rst_n low during WAIT → MemBusyM=0 immediately, all outputs 0, memory unchanged.
